alu_control_pipe: RTL

//   Registered, parametrised ALU control stage between ID and EX of the MIPS pipeline.

---
 rtl/alu_control_pipe.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_control_pipe.sv
// Registered ALU control stage between ID and EX: decodes ALUOp/funct into an ALU code,
// flags unsupported encodings and stalls upstream while a multi-cycle MUL is in flight.
module alu_control_pipe #(
  parameter int ALUOP_W    = 3,
  parameter int FUNCT_W    = 6,
  parameter int CTRL_W     = 6,
  parameter int MUL_CYCLES = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               in_valid,
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               flush,
  output logic [CTRL_W-1:0]  ALUControl,
  output logic               out_valid,
  output logic               illegal,
  output logic               stall
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_MUL = 6'b011000;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SLL = 6'b000000;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SLT = 6'b101010;

  typedef enum logic {IDLE, MUL_WAIT} state_t;

  state_t            state, nextState;
  logic [CNT_W-1:0]  count, nextCount;
  logic [CTRL_W-1:0] nextCtrl;
  logic              nextOutValid, nextIllegal;
  logic [5:0]        decCode;
  logic              decIllegal, decIsMul;

  // Pure decode of the presented op; illegal encodings resolve to a harmless ADD.
  always_comb begin
    decCode    = OP_ADD;
    decIllegal = 1'b0;
    decIsMul   = 1'b0;
    if ((ALUOp >> 3) != '0) begin
      decIllegal = 1'b1;
    end else begin
      case (ALUOp[2:0])
        3'b000: begin
          if ((funct >> 6) != '0) begin
            decIllegal = 1'b1;
          end else begin
            case (funct[5:0])
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR,
              OP_XOR, OP_SLL, OP_SRL, OP_SLT: decCode = funct[5:0];
              OP_MUL: begin
                decCode  = OP_MUL;
                decIsMul = 1'b1;
              end
              default: decIllegal = 1'b1;
            endcase
          end
        end
        3'b001:  decCode = OP_ADD;
        3'b010:  decCode = OP_SUB;
        3'b011:  decCode = OP_AND;
        3'b100:  decCode = OP_OR;
        3'b101:  decCode = OP_XOR;
        3'b110:  decCode = OP_SLT;
        default: decIllegal = 1'b1;
      endcase
    end
    if (decIllegal) decCode = OP_ADD;
  end

  // Next-state and next-output logic; flush wins over both accepts and MUL completion.
  always_comb begin
    nextState    = state;
    nextCount    = count;
    nextCtrl     = ALUControl;
    nextOutValid = 1'b0;
    nextIllegal  = 1'b0;
    case (state)
      IDLE: begin
        if (flush) begin
          nextCtrl = '0;
        end else if (in_valid) begin
          nextCtrl     = CTRL_W'(decCode);
          nextOutValid = 1'b1;
          nextIllegal  = decIllegal;
          if (decIsMul && (MUL_CYCLES > 1)) begin
            nextState = MUL_WAIT;
            nextCount = MUL_LOAD;
          end
        end
      end
      MUL_WAIT: begin
        if (flush) begin
          nextState = IDLE;
          nextCount = '0;
          nextCtrl  = '0;
        end else if (count == CNT_W'(1)) begin
          nextState = IDLE;
          nextCount = '0;
        end else begin
          nextCount = count - CNT_W'(1);
        end
      end
      default: begin
        nextState = IDLE;
        nextCount = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      count      <= '0;
      ALUControl <= '0;
      out_valid  <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      state      <= nextState;
      count      <= nextCount;
      ALUControl <= nextCtrl;
      out_valid  <= nextOutValid;
      illegal    <= nextIllegal;
    end
  end

  assign stall = (state == MUL_WAIT);

endmodule
